id_ex_mem_ctrl: RTL and testbench
=================================

ID_EX_MEM_CTRL -- requirements
Module: id_ex_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: register-file, immediate and ALU data width.
REQ-002 Parameter PC_W, default 16: program-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 opcode  input  6  opcode field of the instruction in ID.
REQ-006 rd  input  5  destination register of the instruction in ID.
REQ-007 rd1, rd2  input  DATA_W each  register-file read data in ID.
REQ-008 sign_imm  input  DATA_W  extended immediate in ID.
REQ-009 pc_count  input  PC_W  PC of the instruction in ID.
REQ-010 flush  input  1  high: ID/EX loads a bubble instead of the ID instruction.
REQ-011 alu_result  input  DATA_W  result from the external ALU in EX.
REQ-012 pc_src, imm_src[1:0], dec_reg_write  output  combinational ID decode.
REQ-013 ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src (1 each), ex_alu_control (5), ex_pc (PC_W), ex_rd1, ex_rd2, ex_imm (DATA_W), ex_rd (5)  output  ID/EX register.
REQ-014 mem_reg_write, mem_mem_to_reg, mem_mem_write (1 each), mem_pc (PC_W), mem_alu_result, mem_wdata (DATA_W), mem_rd (5)  output  EX/MEM register.

Function
REQ-015 Decode SHALL be purely combinational from opcode.
REQ-016 Default for every decoded signal SHALL be 0, including NOP (000000) and all unlisted opcodes.
REQ-017 ALU encodings SHALL be: ADD 00001, SUB 00010, AND 00011, OR 00100, XOR 00101, SLL 00110, SRL 00111, MUL 01000.
REQ-018 Opcodes 00_0001..00_1000 (R-type) SHALL give reg_write=1, alu_src=0, alu_control={0,opcode[3:0]}.
REQ-019 Opcodes 01_0001..01_1000 (I-type) SHALL give reg_write=1, alu_src=1, imm_src=00, alu_control={0,opcode[3:0]}.
REQ-020 LOAD 100000 SHALL give reg_write=1, mem_to_reg=1, alu_src=1, imm_src=01, alu_control=ADD.
REQ-021 STORE 100001 SHALL give mem_write=1, alu_src=1, imm_src=01, alu_control=ADD, reg_write=0.
REQ-022 BRANCH 110000 SHALL give pc_src=1, imm_src=10; all other signals 0.
REQ-023 Opcodes 00_1001..00_1111 and 01_1001..01_1111 SHALL decode as NOP.
REQ-024 ID/EX capture: each rising edge, ex_* SHALL load the decoded controls plus rd1, rd2, sign_imm, pc_count and rd; latency exactly 1 cycle.
REQ-025 When flush=1 at the edge, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src and ex_alu_control SHALL load 0; data fields SHALL still load.
REQ-026 EX/MEM capture: each rising edge, mem_* SHALL load ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_pc, alu_result, ex_rd2 (as mem_wdata) and ex_rd; latency exactly 1 cycle.
REQ-027 Decode to mem_* SHALL be exactly 2 cycles; no stall, no forwarding, no hazard logic in this block.
REQ-028 Back-to-back instructions SHALL advance every cycle with no loss or duplication.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, clear every ex_* and mem_* output to 0.
REQ-030 While rst=1, registers SHALL hold 0; decode outputs SHALL still follow opcode.
REQ-031 First edge after rst falls SHALL capture normally.
REQ-032 Reset asserted mid-stream SHALL discard both in-flight stages.

Verification
REQ-033 Reset: drive rst=1 between edges -> all ex_*/mem_* = 0 at once; release rst, opcode=000001 -> next edge ex_reg_write=1, ex_alu_control=00001.
REQ-034 Decode sweep: all 64 opcodes -> outputs match REQ-016..023 (e.g. 010010 -> alu_src=1, alu_control=00010; 111111 -> all 0).
REQ-035 Pipeline: LOAD with rd=5, pc_count=0x0010, sign_imm=8, alu_result=0x108 -> after 2 edges mem_mem_to_reg=1, mem_reg_write=1, mem_rd=5, mem_pc=0x0010, mem_alu_result=0x108.
REQ-036 Store: STORE with rd2=0xDEADBEEF -> after 2 edges mem_mem_write=1, mem_wdata=0xDEADBEEF, mem_reg_write=0.
REQ-037 Flush: BRANCH in ID gives pc_src=1; next opcode=000001 with flush=1 -> ex_reg_write=0, ex_alu_control=0; one edge later mem_reg_write=0.
REQ-038 Streaming: 4 consecutive distinct ops, one per cycle -> each appears in ex_* then mem_* in order, 1 cycle apart.

Source files
------------

// File: rtl/id_ex_mem_ctrl.sv
// -----------------------------------------------------------------------------
// id_ex_mem_ctrl
//   Instruction decode plus the ID/EX and EX/MEM pipeline registers of a simple
//   in-order pipeline. Decode is purely combinational from the opcode; both
//   pipeline stages advance every cycle (no stall, forwarding or hazard logic).
//
// Ports
//   clk, rst          clock; asynchronous active-high reset of all ex_*/mem_*
//   opcode, rd        opcode and destination register of the instruction in ID
//   rd1, rd2          register-file read data in ID
//   sign_imm          extended immediate in ID
//   pc_count          PC of the instruction in ID
//   flush             1: ID/EX control fields load a bubble (data still loads)
//   alu_result        result of the external ALU working on the EX instruction
//   pc_src, imm_src,  combinational ID decode outputs
//   dec_reg_write
//   ex_*              ID/EX register contents
//   mem_*             EX/MEM register contents
// -----------------------------------------------------------------------------
module id_ex_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  input  logic [DATA_W-1:0] sign_imm,
  input  logic [PC_W-1:0]   pc_count,
  input  logic              flush,
  input  logic [DATA_W-1:0] alu_result,
  output logic              pc_src,
  output logic [1:0]        imm_src,
  output logic              dec_reg_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic [4:0]        ex_alu_control,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic              mem_mem_write,
  output logic [PC_W-1:0]   mem_pc,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [4:0]        mem_rd
);

  localparam logic [5:0] OP_LOAD   = 6'b100000;
  localparam logic [5:0] OP_STORE  = 6'b100001;
  localparam logic [5:0] OP_BRANCH = 6'b110000;
  localparam logic [4:0] ALU_ADD   = 5'b00001;

  logic       dec_mem_to_reg;
  logic       dec_mem_write;
  logic       dec_alu_src;
  logic [4:0] dec_alu_control;
  logic       alu_fn_valid;

  // Low nibble 1..8 selects one of the eight ALU operations; the function code
  // doubles as the ALU encoding, so 9..15 in the ALU groups are treated as NOP.
  assign alu_fn_valid = (opcode[3:0] != 4'd0) && (opcode[3:0] <= 4'd8);

  always_comb begin
    dec_reg_write   = 1'b0;
    dec_mem_to_reg  = 1'b0;
    dec_mem_write   = 1'b0;
    dec_alu_src     = 1'b0;
    dec_alu_control = 5'd0;
    pc_src          = 1'b0;
    imm_src         = 2'b00;
    case (opcode[5:4])
      2'b00: begin  // R-type
        if (alu_fn_valid) begin
          dec_reg_write   = 1'b1;
          dec_alu_control = {1'b0, opcode[3:0]};
        end
      end
      2'b01: begin  // I-type
        if (alu_fn_valid) begin
          dec_reg_write   = 1'b1;
          dec_alu_src     = 1'b1;
          dec_alu_control = {1'b0, opcode[3:0]};
        end
      end
      default: begin
        case (opcode)
          OP_LOAD: begin
            dec_reg_write   = 1'b1;
            dec_mem_to_reg  = 1'b1;
            dec_alu_src     = 1'b1;
            imm_src         = 2'b01;
            dec_alu_control = ALU_ADD;
          end
          OP_STORE: begin
            dec_mem_write   = 1'b1;
            dec_alu_src     = 1'b1;
            imm_src         = 2'b01;
            dec_alu_control = ALU_ADD;
          end
          OP_BRANCH: begin
            pc_src  = 1'b1;
            imm_src = 2'b10;
          end
          default: ;
        endcase
      end
    endcase
  end

  // ID/EX: a flush turns only the control fields into a bubble; the data fields
  // are loaded regardless since nothing downstream acts on them without controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_alu_control <= 5'd0;
      ex_pc          <= '0;
      ex_rd1         <= '0;
      ex_rd2         <= '0;
      ex_imm         <= '0;
      ex_rd          <= 5'd0;
    end else begin
      ex_reg_write   <= dec_reg_write   & ~flush;
      ex_mem_to_reg  <= dec_mem_to_reg  & ~flush;
      ex_mem_write   <= dec_mem_write   & ~flush;
      ex_alu_src     <= dec_alu_src     & ~flush;
      ex_alu_control <= flush ? 5'd0 : dec_alu_control;
      ex_pc          <= pc_count;
      ex_rd1         <= rd1;
      ex_rd2         <= rd2;
      ex_imm         <= sign_imm;
      ex_rd          <= rd;
    end
  end

  // EX/MEM: rd2 travels on as the store write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_reg_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_pc         <= '0;
      mem_alu_result <= '0;
      mem_wdata      <= '0;
      mem_rd         <= 5'd0;
    end else begin
      mem_reg_write  <= ex_reg_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_mem_write  <= ex_mem_write;
      mem_pc         <= ex_pc;
      mem_alu_result <= alu_result;
      mem_wdata      <= ex_rd2;
      mem_rd         <= ex_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_ex_mem_ctrl
//   Directed bench for id_ex_mem_ctrl. A history of the instructions presented
//   at each clock edge is kept; the expected ex_*/mem_* values are derived from
//   that history and a table-style decode function, and compared on every
//   falling edge. Literal expectations pin the key scenarios independently.
// -----------------------------------------------------------------------------
module tb_id_ex_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [31:0] rd1, rd2, sign_imm, alu_result;
  logic [15:0] pc_count;
  logic        flush;
  logic        pc_src, dec_reg_write;
  logic [1:0]  imm_src;
  logic        ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src;
  logic [4:0]  ex_alu_control, ex_rd;
  logic [15:0] ex_pc;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic        mem_reg_write, mem_mem_to_reg, mem_mem_write;
  logic [15:0] mem_pc;
  logic [31:0] mem_alu_result, mem_wdata;
  logic [4:0]  mem_rd;

  int errors = 0;
  int checks = 0;

  id_ex_mem_ctrl #(.DATA_W(32), .PC_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .rd(rd), .rd1(rd1), .rd2(rd2),
    .sign_imm(sign_imm), .pc_count(pc_count), .flush(flush),
    .alu_result(alu_result), .pc_src(pc_src), .imm_src(imm_src),
    .dec_reg_write(dec_reg_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_control(ex_alu_control), .ex_pc(ex_pc),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_mem_write(mem_mem_write), .mem_pc(mem_pc),
    .mem_alu_result(mem_alu_result), .mem_wdata(mem_wdata), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       asrc;
    logic       psrc;
    logic [1:0] isrc;
    logic [4:0] actl;
  } dec_t;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] rd1, rd2, imm, alu;
    logic [15:0] pc;
    logic        fl;
  } rec_t;

  // Instruction table: ALU groups 0 and 1 with function 1..8, plus three
  // memory/branch opcodes; everything else is a NOP.
  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    int grp;
    int fn;
    d   = '0;
    grp = int'(op) / 16;
    fn  = int'(op) % 16;
    if (op == 6'd32) begin
      d.rw = 1'b1; d.m2r = 1'b1; d.asrc = 1'b1; d.isrc = 2'd1; d.actl = 5'd1;
    end else if (op == 6'd33) begin
      d.mw = 1'b1; d.asrc = 1'b1; d.isrc = 2'd1; d.actl = 5'd1;
    end else if (op == 6'd48) begin
      d.psrc = 1'b1; d.isrc = 2'd2;
    end else if (grp <= 1 && fn >= 1 && fn <= 8) begin
      d.rw   = 1'b1;
      d.asrc = (grp == 1);
      d.actl = 5'(fn);
    end
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // History of instructions captured since the last reset (last two suffice).
  rec_t hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
    end else begin
      rec_t r;
      r.op = opcode; r.rd = rd; r.rd1 = rd1; r.rd2 = rd2; r.imm = sign_imm;
      r.alu = alu_result; r.pc = pc_count; r.fl = flush;
      hist.push_back(r);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end

  // Per-cycle comparison against the history-based expectation.
  always @(negedge clk) begin
    dec_t        d, hd;
    rec_t        h;
    logic [8:0]  e_ctl;
    logic [2:0]  m_ctl;
    logic [15:0] e_pc, m_pc;
    logic [31:0] e_rd1, e_rd2, e_imm, m_alu, m_wd;
    logic [4:0]  e_rd, m_rd;
    int          n;
    d = decode(opcode);
    chk("decode", {61'd0, pc_src, imm_src}, {61'd0, d.psrc, d.isrc});
    chk("dec_reg_write", {63'd0, dec_reg_write}, {63'd0, d.rw});
    e_ctl = '0; e_pc = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_rd = '0;
    m_ctl = '0; m_pc = '0; m_alu = '0; m_wd = '0; m_rd = '0;
    n = hist.size();
    if (!rst && n >= 1) begin
      h  = hist[n-1];
      hd = decode(h.op);
      e_ctl = h.fl ? 9'd0 : {hd.rw, hd.m2r, hd.mw, hd.asrc, hd.actl};
      e_pc = h.pc; e_rd1 = h.rd1; e_rd2 = h.rd2; e_imm = h.imm; e_rd = h.rd;
    end
    if (!rst && n >= 2) begin
      h  = hist[n-2];
      hd = decode(h.op);
      m_ctl = h.fl ? 3'd0 : {hd.rw, hd.m2r, hd.mw};
      m_pc = h.pc; m_wd = h.rd2; m_rd = h.rd;
      m_alu = hist[n-1].alu;
    end
    chk("ex_ctrl", {55'd0, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_alu_control},
        {55'd0, e_ctl});
    chk("ex_data", {ex_pc, ex_rd, ex_rd1[31:0], 11'd0}, {e_pc, e_rd, e_rd1, 11'd0});
    chk("ex_rd2_imm", {ex_rd2, ex_imm}, {e_rd2, e_imm});
    chk("mem_ctrl", {61'd0, mem_reg_write, mem_mem_to_reg, mem_mem_write}, {61'd0, m_ctl});
    chk("mem_data", {mem_pc, mem_rd, 11'd0, mem_alu_result}, {m_pc, m_rd, 11'd0, m_alu});
    chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m_wd});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [15:0] pc,
                       input logic fl, input logic [31:0] alu);
    opcode = op; rd = r; rd1 = a; rd2 = b; sign_imm = imm; pc_count = pc;
    flush = fl; alu_result = alu;
  endtask

  logic [5:0] s_ops [4];
  logic [4:0] s_alu [4];

  initial begin
    s_ops = '{6'b000001, 6'b010011, 6'b100000, 6'b000110};
    s_alu = '{5'd1, 5'd3, 5'd1, 5'd6};
    rst = 1'b1;
    drive(6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd0, 1'b0, 32'd0);
    tick(); tick();
    chk("reset_ex_reg_write", {63'd0, ex_reg_write}, 64'd0);
    chk("reset_mem_wdata", {32'd0, mem_wdata}, 64'd0);

    // Release between edges, first edge captures an ADD.
    drive(6'b000001, 5'd1, 32'h11, 32'h22, 32'h33, 16'h4, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    chk("first_ex_reg_write", {63'd0, ex_reg_write}, 64'd1);
    chk("first_ex_alu_control", {59'd0, ex_alu_control}, 64'd1);

    // Decode sweep over all opcodes.
    for (int i = 0; i < 64; i++) begin
      drive(6'(i), 5'(i), $urandom, $urandom, $urandom, 16'($urandom), 1'b0, $urandom);
      tick();
      if (i == 18) begin
        chk("sweep_010010_alu_src", {63'd0, ex_alu_src}, 64'd1);
        chk("sweep_010010_alu_ctl", {59'd0, ex_alu_control}, 64'd2);
      end
      if (i == 63)
        chk("sweep_111111_ctrl", {55'd0, ex_reg_write, ex_mem_to_reg, ex_mem_write,
            ex_alu_src, ex_alu_control}, 64'd0);
    end

    // LOAD through both stages.
    drive(6'b100000, 5'd5, 32'h100, 32'h7, 32'd8, 16'h0010, 1'b0, 32'h0);
    tick();
    drive(6'b000000, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0014, 1'b0, 32'h108);
    tick();
    chk("load_mem_to_reg", {63'd0, mem_mem_to_reg}, 64'd1);
    chk("load_reg_write", {63'd0, mem_reg_write}, 64'd1);
    chk("load_rd", {59'd0, mem_rd}, 64'd5);
    chk("load_pc", {48'd0, mem_pc}, 64'h10);
    chk("load_alu", {32'd0, mem_alu_result}, 64'h108);

    // STORE through both stages.
    drive(6'b100001, 5'd9, 32'h200, 32'hDEADBEEF, 32'd4, 16'h0018, 1'b0, 32'h0);
    tick();
    drive(6'b000000, 5'd0, 32'h0, 32'h0, 32'h0, 16'h001C, 1'b0, 32'h204);
    tick();
    chk("store_mem_write", {63'd0, mem_mem_write}, 64'd1);
    chk("store_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    chk("store_reg_write", {63'd0, mem_reg_write}, 64'd0);

    // BRANCH then a flushed ADD.
    drive(6'b110000, 5'd0, 32'h0, 32'h0, 32'h40, 16'h0020, 1'b0, 32'h0);
    #1;
    chk("branch_pc_src", {63'd0, pc_src}, 64'd1);
    chk("branch_imm_src", {62'd0, imm_src}, 64'd2);
    tick();
    drive(6'b000001, 5'd3, 32'h1, 32'h2, 32'h0, 16'h0024, 1'b1, 32'h0);
    tick();
    chk("flush_ex_reg_write", {63'd0, ex_reg_write}, 64'd0);
    chk("flush_ex_alu_control", {59'd0, ex_alu_control}, 64'd0);
    chk("flush_ex_rd", {59'd0, ex_rd}, 64'd3);
    drive(6'b000000, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0028, 1'b0, 32'h0);
    tick();
    chk("flush_mem_reg_write", {63'd0, mem_reg_write}, 64'd0);

    // Four back-to-back distinct instructions.
    for (int k = 0; k < 4; k++) begin
      drive(s_ops[k], 5'(k + 1), 32'(k), 32'(k * 3), 32'(k * 5), 16'(16'h100 + k * 4), 1'b0,
            32'(k * 7));
      tick();
      chk("stream_ex_rd", {59'd0, ex_rd}, 64'(k + 1));
      chk("stream_ex_alu", {59'd0, ex_alu_control}, {59'd0, s_alu[k]});
      if (k > 0) chk("stream_mem_rd", {59'd0, mem_rd}, 64'(k));
    end
    drive(6'b000000, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 1'b0, 32'h0);
    tick();
    chk("stream_last_mem_rd", {59'd0, mem_rd}, 64'd4);

    // Reset mid-stream: asynchronous clear, decode stays live.
    drive(6'b000010, 5'd7, 32'h5, 32'h6, 32'h7, 16'h200, 1'b0, 32'h0);
    tick();
    drive(6'b000011, 5'd8, 32'h5, 32'h6, 32'h7, 16'h204, 1'b0, 32'h99);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_ex_reg_write", {63'd0, ex_reg_write}, 64'd0);
    chk("midrst_ex_rd1", {32'd0, ex_rd1}, 64'd0);
    chk("midrst_mem_reg_write", {63'd0, mem_reg_write}, 64'd0);
    chk("midrst_mem_alu", {32'd0, mem_alu_result}, 64'd0);
    drive(6'b100000, 5'd2, 32'h1, 32'h1, 32'h1, 16'h208, 1'b0, 32'h0);
    #1;
    chk("midrst_dec_reg_write", {63'd0, dec_reg_write}, 64'd1);
    chk("midrst_imm_src", {62'd0, imm_src}, 64'd1);
    tick();
    chk("midrst_hold_ex_rd", {59'd0, ex_rd}, 64'd0);
    drive(6'b000001, 5'd6, 32'h1, 32'h1, 32'h1, 16'h20C, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    chk("postrst_ex_reg_write", {63'd0, ex_reg_write}, 64'd1);
    chk("postrst_mem_reg_write", {63'd0, mem_reg_write}, 64'd0);
    chk("postrst_mem_rd", {59'd0, mem_rd}, 64'd0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
